// File: rtl/regfile_multiport.sv
// Two-write, two-read register file with per-register busy scoreboard; register 0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and busy clears) onto the read ports.
module regfile_multiport #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  WriteEnA,
    input  logic [ADDR_WIDTH-1:0] WriteRegA,
    input  logic [WIDTH-1:0]      WriteDataA,
    input  logic                  WriteEnB,
    input  logic [ADDR_WIDTH-1:0] WriteRegB,
    input  logic [WIDTH-1:0]      WriteDataB,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2,
    input  logic                  ReserveEn,
    input  logic [ADDR_WIDTH-1:0] ReserveReg,
    output logic                  Busy1,
    output logic                  Busy2,
    output logic                  Conflict
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      regs_q  [DEPTH];
    logic [WIDTH-1:0]      regs_d  [DEPTH];
    logic                  busy_q  [DEPTH];
    logic                  busy_d  [DEPTH];
    logic                  conflict_q;
    logic                  conflict_d;

    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [WIDTH-1:0]      rd_data [2];
    logic                  rd_busy [2];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_d[gi] = '0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_live
                logic hit_a;
                logic hit_b;
                logic hit_res;
                assign hit_a   = WriteEnA  && (WriteRegA  == ADDR_WIDTH'(gi));
                assign hit_b   = WriteEnB  && (WriteRegB  == ADDR_WIDTH'(gi));
                assign hit_res = ReserveEn && (ReserveReg == ADDR_WIDTH'(gi));
                // Port B wins a same-address collision.
                assign regs_d[gi] = hit_b ? WriteDataB : (hit_a ? WriteDataA : regs_q[gi]);
                // A new reservation outranks the completion of the previous producer.
                assign busy_d[gi] = hit_res ? 1'b1 : ((hit_a || hit_b) ? 1'b0 : busy_q[gi]);
            end
        end
    endgenerate

    always_comb begin
        conflict_d = WriteEnA && WriteEnB && (WriteRegA == WriteRegB) && (WriteRegA != '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
                busy_q[i] <= 1'b0;
            end
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
                busy_q[i] <= busy_d[i];
            end
            conflict_q <= conflict_d;
        end
    end

    assign rd_addr[0] = ReadRegister1;
    assign rd_addr[1] = ReadRegister2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
            logic hit_a;
            logic hit_b;
            logic hit_res;
            assign hit_a   = WriteEnA  && (WriteRegA  == rd_addr[gi]);
            assign hit_b   = WriteEnB  && (WriteRegB  == rd_addr[gi]);
            assign hit_res = ReserveEn && (ReserveReg == rd_addr[gi]);
`endif
            always_comb begin
                rd_data[gi] = regs_q[rd_addr[gi]];
                rd_busy[gi] = busy_q[rd_addr[gi]];
`ifdef REGFILE_BYPASS_EN
                if (rd_addr[gi] != '0) begin
                    if (hit_b) begin
                        rd_data[gi] = WriteDataB;
                    end else if (hit_a) begin
                        rd_data[gi] = WriteDataA;
                    end
                    if ((hit_a || hit_b) && !hit_res) begin
                        rd_busy[gi] = 1'b0;
                    end
                end
`endif
            end
        end
    endgenerate

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign Busy1     = rd_busy[0];
    assign Busy2     = rd_busy[1];
    assign Conflict  = conflict_q;

endmodule
